// File: rtl/hilo_muldiv_ctrl_if.sv
// EX-stage <-> HI/LO mul/div sequencer connection.
// The master side (EX stage) issues ops and MTHI/MTLO writes.
// The slave side (sequencer) returns stall, done and the HI/LO value.
interface hilo_muldiv_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hilo_we;
    logic [63:0] hilo_wdata;
    logic        stall;
    logic        done;
    logic [63:0] hilo;

    modport master (
        output start, op, a, b, flush, hilo_we, hilo_wdata,
        input  stall, done, hilo
    );

    modport slave (
        input  start, op, a, b, flush, hilo_we, hilo_wdata,
        output stall, done, hilo
    );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO register.
// A multiply occupies MUL_LAT cycles in MUL. A divide runs 32 restoring steps in DIV,
// one per cycle, on operand magnitudes; the sign fix-up is applied when {HI,LO} is written.
// MTHI/MTLO writes land only while idle.
module hilo_muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    hilo_muldiv_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] a_q, b_q;
    logic [1:0]  op_q;
    logic [63:0] rem_q;
    logic [31:0] quot_q;
    logic [63:0] hilo_q;
    logic        done_q;

    logic        launch;
    logic        finish;
    logic        stall;

    // op[0]=0 selects the signed forms (MULT/DIV)
    logic        is_signed;
    logic [63:0] mul_a, mul_b, product;
    logic [31:0] divisor;
    logic [63:0] div_shift, div_rem_nx;
    logic        div_ge;
    logic [31:0] div_quot_nx;
    logic [31:0] quot_fix, rem_fix;
    logic [63:0] div_result;
    logic [31:0] a_abs;

    // Next state, launch/finish strobes and the pipeline stall
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        finish  = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    launch  = 1'b1;
                    stall   = 1'b1;
                    state_d = bus.op[1] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                stall = 1'b1;
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 5'd0) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Multiplier and one restoring-division step, both from the latched operands
    always_comb begin
        is_signed   = !op_q[0];
        mul_a       = {{32{is_signed & a_q[31]}}, a_q};
        mul_b       = {{32{is_signed & b_q[31]}}, b_q};
        product     = mul_a * mul_b;

        divisor     = (is_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
        div_shift   = {rem_q[62:0], quot_q[31]};
        div_ge      = div_shift >= {32'd0, divisor};
        div_rem_nx  = div_ge ? (div_shift - {32'd0, divisor}) : div_shift;
        div_quot_nx = {quot_q[30:0], div_ge};

        // Quotient is negative when the operand signs differ; the remainder follows the dividend.
        quot_fix    = (is_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - div_quot_nx) : div_quot_nx;
        rem_fix     = (is_signed && a_q[31]) ? (32'd0 - div_rem_nx[31:0]) : div_rem_nx[31:0];
        // Divide by zero still runs all steps but reports HI=a, LO=all ones for both kinds.
        div_result  = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem_fix, quot_fix};
    end

    // Magnitude of the incoming dividend, loaded into the quotient shifter at launch
    always_comb begin
        a_abs = (!bus.op[0] && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand latches, step counter, division registers, HI/LO and the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= 5'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            op_q   <= 2'd0;
            rem_q  <= 64'd0;
            quot_q <= 32'd0;
            hilo_q <= 64'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;

            if (launch) begin
                a_q    <= bus.a;
                b_q    <= bus.b;
                op_q   <= bus.op;
                rem_q  <= 64'd0;
                quot_q <= a_abs;
                cnt_q  <= bus.op[1] ? 5'd31 : 5'(MUL_LAT - 1);
            end else if (state_q != IDLE && cnt_q != 5'd0) begin
                cnt_q <= cnt_q - 5'd1;
            end

            if (state_q == DIV) begin
                rem_q  <= div_rem_nx;
                quot_q <= div_quot_nx;
            end

            // MTHI/MTLO only while idle; a completing op writes its result unless flushed.
            if (state_q == IDLE && bus.hilo_we) begin
                hilo_q <= bus.hilo_wdata;
            end else if (finish) begin
                hilo_q <= (state_q == MUL) ? product : div_result;
            end
        end
    end

    assign bus.stall = stall;
    assign bus.done  = done_q;
    assign bus.hilo  = hilo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl (MUL_LAT=2): a vector table of mul/div ops
// with hand-computed results and stall lengths, plus sequences for MTHI/MTLO,
// flush, same-cycle start+write and asynchronous reset.
module tb_hilo_muldiv_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_muldiv_ctrl_if bus();

    hilo_muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        int          cycles;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input string name, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [63:0] hilo, input int cycles);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.hilo = hilo; v.cycles = cycles;
        return v;
    endfunction

    // Launch one op at a falling edge, count stall cycles, then check result and done.
    task automatic run_op(input vec_t v);
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.op = v.op; bus.a = v.a; bus.b = v.b;
        #1;
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.start = 1'b0;
        check({v.name, " stall cycles"}, 64'(n), 64'(v.cycles));
        check({v.name, " done pulse"}, 64'(bus.done), 64'd1);
        check({v.name, " hilo"}, bus.hilo, v.hilo);
        @(posedge clk); #1;
        check({v.name, " done drops"}, 64'(bus.done), 64'd0);
    endtask

    task automatic write_hilo(input logic [63:0] val);
        @(negedge clk);
        bus.hilo_we = 1'b1; bus.hilo_wdata = val;
        @(negedge clk);
        bus.hilo_we = 1'b0;
    endtask

    initial begin
        int n;

        vecs[0]  = mk("mult -3*7",        2'b00, 32'hFFFF_FFFD, 32'd7,        64'hFFFFFFFF_FFFFFFEB, 3);
        vecs[1]  = mk("multu fffffffd*7", 2'b01, 32'hFFFF_FFFD, 32'd7,        64'h00000006_FFFFFFEB, 3);
        vecs[2]  = mk("mult min*min",     2'b00, 32'h8000_0000, 32'h8000_0000, 64'h40000000_00000000, 3);
        vecs[3]  = mk("multu max*max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFFFFFE_00000001, 3);
        vecs[4]  = mk("mult -1*1",        2'b00, 32'hFFFF_FFFF, 32'd1,        64'hFFFFFFFF_FFFFFFFF, 3);
        vecs[5]  = mk("divu 100/7",       2'b11, 32'd100,       32'd7,        {32'd2, 32'd14},       33);
        vecs[6]  = mk("div -7/2",         2'b10, 32'hFFFF_FFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33);
        vecs[7]  = mk("div min/-1",       2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);
        vecs[8]  = mk("divu 5/0",         2'b11, 32'd5,         32'd0,        64'h00000005_FFFFFFFF, 33);
        vecs[9]  = mk("div 7/-2",         2'b10, 32'd7,         32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33);
        vecs[10] = mk("div -5/0",         2'b10, 32'hFFFF_FFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 33);
        vecs[11] = mk("divu max/1",       2'b11, 32'hFFFF_FFFF, 32'd1,        64'h00000000_FFFFFFFF, 33);
        vecs[12] = mk("div -8/-3",        2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 64'hFFFFFFFE_00000002, 33);

        bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
        bus.flush = 1'b0; bus.hilo_we = 1'b0; bus.hilo_wdata = 64'd0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset hilo", bus.hilo, 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset stall", 64'(bus.stall), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // MTHI/MTLO write in IDLE: visible next cycle, no done.
        @(negedge clk);
        bus.hilo_we = 1'b1; bus.hilo_wdata = 64'h00000001_00000002;
        #1 check("hilo_we no stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.hilo_we = 1'b0;
        check("hilo_we value", bus.hilo, 64'h00000001_00000002);
        check("hilo_we no done", 64'(bus.done), 64'd0);

        // hilo_we during DIV is ignored; the divide result still lands.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.hilo_we = 1'b1; bus.hilo_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        bus.hilo_we = 1'b0;
        check("we in div ignored", bus.hilo, 64'h00000001_00000002);
        n = 0;
        while (bus.stall && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("we in div stall ends", 64'(bus.stall), 64'd0);
        check("we in div result", bus.hilo, {32'd2, 32'd14});
        check("we in div done", 64'(bus.done), 64'd1);

        // Flush at DIV cycle 10: back to IDLE, hilo unchanged, no done.
        write_hilo(64'h1111_2222_3333_4444);
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        check("flush div still stalling", 64'(bus.stall), 64'd1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush div stall", 64'(bus.stall), 64'd0);
        check("flush div hilo", bus.hilo, 64'h1111_2222_3333_4444);
        check("flush div done", 64'(bus.done), 64'd0);
        repeat (30) begin
            @(posedge clk); #1;
            check("flush div never done", 64'(bus.done), 64'd0);
        end

        // Flush beats the completion edge of a multiply.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush at finish hilo", bus.hilo, 64'h1111_2222_3333_4444);
        check("flush at finish stall", 64'(bus.stall), 64'd0);
        check("flush at finish done", 64'(bus.done), 64'd0);

        // Flush in IDLE blocks start.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9;
        #1 check("idle flush no stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("idle flush stays idle", 64'(bus.stall), 64'd0);
        repeat (3) @(posedge clk);
        #1 check("idle flush hilo", bus.hilo, 64'h1111_2222_3333_4444);
        check("idle flush no done", 64'(bus.done), 64'd0);

        // Same-cycle hilo_we and start: write lands, then the multiply overwrites.
        @(negedge clk);
        bus.hilo_we = 1'b1; bus.hilo_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.hilo_we = 1'b0; bus.start = 1'b0;
        check("same cycle write", bus.hilo, 64'hAAAA_BBBB_CCCC_DDDD);
        check("same cycle stalling", 64'(bus.stall), 64'd1);
        repeat (2) @(posedge clk);
        #1 check("same cycle result", bus.hilo, 64'd6);
        check("same cycle done", 64'(bus.done), 64'd1);
        check("same cycle stall end", 64'(bus.stall), 64'd0);

        // Asynchronous reset mid-MUL clears hilo immediately.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd4; bus.b = 32'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        rst = 1'b1;
        #1 check("async rst hilo", bus.hilo, 64'd0);
        check("async rst stall", 64'(bus.stall), 64'd0);
        check("async rst done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("post rst no done", 64'(bus.done), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
